mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
Two-host to one-device arbiter for the core's memory bus, sharing the on-chip SRAM between the Ibex instruction port (host 0) and data port (host 1).
- All sides use the req/gnt/rvalid protocol; the device responds in order with variable latency.
- Tracks outstanding transactions in an owner FIFO and routes each response back to the host that issued it.
- Sits between the core and a single-port SRAM or bus fabric.

Parameters:
AddrWidth, 32, address width on all ports
DataWidth, 32, data width; byte enable width is DataWidth/8
MaxOutstanding, 2, owner FIFO depth; minimum 1; a power of two is not required
FixedPriority, 0, 0 = round-robin; 1 = host 1 always wins a tie

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
h0_req_i / h0_addr_i  in  1/AddrWidth  instruction request (read-only)
h0_gnt_o / h0_rvalid_o  out  1/1  instruction grant and response valid
h1_req_i / h1_we_i / h1_be_i  in  1/1/DataWidth/8  data request, write enable, byte enables
h1_addr_i / h1_wdata_i  in  AddrWidth/DataWidth  data address and write data
h1_gnt_o / h1_rvalid_o  out  1/1  data grant and response valid
host_rdata_o / host_err_o  out  DataWidth/1  response payload, broadcast to both hosts
dev_req_o / dev_we_o / dev_be_o  out  1/1/DataWidth/8  device request
dev_addr_o / dev_wdata_o  out  AddrWidth/DataWidth  device address and write data
dev_gnt_i / dev_rvalid_i  in  1/1  device grant and response valid
dev_rdata_i / dev_err_i  in  DataWidth/1  device response payload
unexpected_rvalid_o  out  1  sticky flag: dev_rvalid_i seen with no outstanding transaction

Behaviour:
- Reset (rst_i high, asynchronous): all registered state cleared; FIFO empty; lock cleared; last-granted = host 1, so host 0 wins the first tie; unexpected_rvalid_o = 0.
- Every combinational output is 0 while both hosts are idle and nothing is outstanding.
- Reset asserted mid-operation drops all in-flight responses; any device rvalid that arrives after release sets unexpected_rvalid_o.
- Full = outstanding count == MaxOutstanding, decided from the registered count.
  - A pop in the same cycle does not unblock a push; there is no combinational path from rvalid to req.
- Selection:
  - If the lock is set, the locked host is selected.
  - Otherwise, if exactly one host requests, that host is selected.
  - If both request:
    - FixedPriority=1: host 1 is selected.
    - FixedPriority=0: the host not granted last is selected.
- dev_req_o = (h0_req_i | h1_req_i) & !full.
- dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o are muxed from the selected host; host 0 drives we=0, be=all-ones, wdata=0.
- hX_gnt_o = (sel==X) & dev_gnt_i & !full. Grant is combinational, zero added latency.
- Handshake = dev_req_o & dev_gnt_i. On a handshake:
  - push sel into the FIFO;
  - update last-granted;
  - clear the lock.
- Lock: if dev_req_o is high and dev_gnt_i is low, lock the current sel, so the device sees a stable request until it grants. The other host's request cannot preempt it.
- Response routing:
  - On dev_rvalid_i with the FIFO non-empty: pop, and assert hX_rvalid_o for X = head owner in the same cycle.
  - host_rdata_o = dev_rdata_i and host_err_o = dev_err_i, both passed through combinationally.
  - Response latency through the arbiter is 0 cycles.
- Simultaneous push and pop in one cycle is legal when not full; the count is unchanged.
- dev_rvalid_i with the FIFO empty:
  - ignored; no host rvalid is asserted;
  - sets unexpected_rvalid_o until reset.
- Host protocol: a host holds req and its fields stable until granted. The arbiter does not check this; the bench asserts it.
- Count width: $clog2(MaxOutstanding+1). FIFO pointers wrap modulo MaxOutstanding.

Decomposition:
- mem_arb_pkg: host_e enum (HOST_INSTR=0, HOST_DATA=1) and policy constants ARB_RR, ARB_FIXED.
- Sub-module mem_arb_owner_fifo:
  - parameterised depth, 1-bit entries;
  - ports push, pop, head, full, empty, count;
  - asynchronous active-high reset.
- The top level holds the selection logic, lock, last-granted register and sticky flag.

Test Plan:
- Single-host read: h0 req at addr 0x80, dev_gnt immediate, dev_rvalid next cycle with rdata 0xDEADBEEF -> h0_gnt same cycle as req, h0_rvalid with 0xDEADBEEF, h1_rvalid=0.
- Round-robin tie: both hosts request continuously, dev_gnt tied high -> grants alternate h0,h1,h0,h1; responses return to owners in the same order.
- Grant lock: both request, dev_gnt low for 3 cycles, then high -> dev_addr constant (host 0 addr) for all 4 cycles; h1 granted next.
- FIFO full: MaxOutstanding=2, dev_gnt high, rvalid withheld -> third request blocked (dev_req_o=0); rvalid and new req in the same cycle -> still blocked that cycle, granted the next.
- Write plus error: h1 write be=0x3 wdata=0x1234 -> dev_we=1, dev_be=0x3; dev_err=1 on response -> h1_rvalid=1, host_err_o=1.
- Spurious and reset: dev_rvalid with nothing outstanding -> no host rvalid, unexpected_rvalid_o=1 until rst_i; rst_i pulse with 2 outstanding -> count 0, flag cleared, first post-reset tie goes to host 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and policy constants for the two-host memory bus arbiter.
package mem_arb_pkg;

  // Owner tag stored per outstanding transaction; value doubles as host index.
  typedef enum logic {
    HOST_INSTR = 1'b0,
    HOST_DATA  = 1'b1
  } host_e;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  function automatic host_e other_host(host_e h);
    return (h == HOST_INSTR) ? HOST_DATA : HOST_INSTR;
  endfunction

endpackage

// File: rtl/mem_arb_owner_fifo.sv
// Owner FIFO: remembers which host issued each outstanding device transaction
// so in-order responses can be steered back. Depth need not be a power of two.
module mem_arb_owner_fifo #(
  parameter int Depth = 2,
  localparam int CntW = $clog2(Depth + 1),
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            push_owner,
  input  logic            pop,
  output logic            head,
  output logic            full,
  output logic            empty,
  output logic [CntW-1:0] count
);

  logic [Depth-1:0] mem;
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CntW'(Depth));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage, pointers and occupancy; push and pop together leave count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_owner;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-host to one-device req/gnt/rvalid arbiter. Host 0 is the instruction
// port (read-only), host 1 the data port. Grants and responses are
// combinational; the owner FIFO routes in-order responses back.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 32,
  parameter int MaxOutstanding = 2,
  parameter int FixedPriority  = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   h0_req_i,
  input  logic [AddrWidth-1:0]   h0_addr_i,
  output logic                   h0_gnt_o,
  output logic                   h0_rvalid_o,
  input  logic                   h1_req_i,
  input  logic                   h1_we_i,
  input  logic [DataWidth/8-1:0] h1_be_i,
  input  logic [AddrWidth-1:0]   h1_addr_i,
  input  logic [DataWidth-1:0]   h1_wdata_i,
  output logic                   h1_gnt_o,
  output logic                   h1_rvalid_o,
  output logic [DataWidth-1:0]   host_rdata_o,
  output logic                   host_err_o,
  output logic                   dev_req_o,
  output logic                   dev_we_o,
  output logic [DataWidth/8-1:0] dev_be_o,
  output logic [AddrWidth-1:0]   dev_addr_o,
  output logic [DataWidth-1:0]   dev_wdata_o,
  input  logic                   dev_gnt_i,
  input  logic                   dev_rvalid_i,
  input  logic [DataWidth-1:0]   dev_rdata_i,
  input  logic                   dev_err_i,
  output logic                   unexpected_rvalid_o
);

  localparam int CntW = $clog2(MaxOutstanding + 1);

  host_e            sel;
  host_e            last_q;
  host_e            lock_owner_q;
  host_e            head_owner;
  logic             lock_q;
  logic             any_req;
  logic             handshake;
  logic             pop;
  logic             head;
  logic             full;
  logic             empty;
  logic [CntW-1:0]  outstanding;
  logic             unexpected_q;

  assign any_req = h0_req_i | h1_req_i;

  // Host selection: a pending lock wins, then a lone requester, then the tie policy.
  always_comb begin
    sel = HOST_INSTR;
    if (lock_q) begin
      sel = lock_owner_q;
    end else if (h0_req_i && !h1_req_i) begin
      sel = HOST_INSTR;
    end else if (h1_req_i && !h0_req_i) begin
      sel = HOST_DATA;
    end else if (h0_req_i && h1_req_i) begin
      if (FixedPriority == ARB_FIXED) begin
        sel = HOST_DATA;
      end else begin
        sel = other_host(last_q);
      end
    end
  end

  // Device request fields follow the selected host; all zero while nobody asks.
  always_comb begin
    dev_addr_o  = '0;
    dev_we_o    = 1'b0;
    dev_be_o    = '0;
    dev_wdata_o = '0;
    if (any_req) begin
      if (sel == HOST_DATA) begin
        dev_addr_o  = h1_addr_i;
        dev_we_o    = h1_we_i;
        dev_be_o    = h1_be_i;
        dev_wdata_o = h1_wdata_i;
      end else begin
        dev_addr_o  = h0_addr_i;
        dev_be_o    = '1;
      end
    end
  end

  // Full comes from the registered occupancy only, so a same-cycle pop
  // never opens a path from dev_rvalid_i to dev_req_o.
  assign dev_req_o   = any_req & ~full;
  assign handshake   = dev_req_o & dev_gnt_i;
  assign h0_gnt_o    = handshake & (sel == HOST_INSTR);
  assign h1_gnt_o    = handshake & (sel == HOST_DATA);

  assign head_owner  = host_e'(head);
  assign pop         = dev_rvalid_i & ~empty;
  assign h0_rvalid_o = pop & (head_owner == HOST_INSTR);
  assign h1_rvalid_o = pop & (head_owner == HOST_DATA);

  assign host_rdata_o        = dev_rdata_i;
  assign host_err_o          = dev_err_i;
  assign unexpected_rvalid_o = unexpected_q;

  mem_arb_owner_fifo #(
    .Depth (MaxOutstanding)
  ) u_owner_fifo (
    .clk        (clk_i),
    .rst        (rst_i),
    .push       (handshake),
    .push_owner (sel),
    .pop        (pop),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .count      (outstanding)
  );

  // Last-granted and lock: an ungranted request pins the selection until accepted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_q       <= 1'b0;
      lock_owner_q <= HOST_INSTR;
      last_q       <= HOST_DATA;
    end else if (handshake) begin
      lock_q <= 1'b0;
      last_q <= sel;
    end else if (dev_req_o) begin
      lock_q       <= 1'b1;
      lock_owner_q <= sel;
    end
  end

  // Sticky flag for a device response with nothing outstanding.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      unexpected_q <= 1'b0;
    end else if (dev_rvalid_i && (outstanding == '0)) begin
      unexpected_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus a
// randomized run checked against a queue-based reference model.
module tb_mem_bus_arbiter;

  localparam int MAXO  = 2;
  localparam int FIXED = 0;

  logic        clk;
  logic        rst;
  logic        h0_req, h0_gnt, h0_rvalid;
  logic [31:0] h0_addr;
  logic        h1_req, h1_we, h1_gnt, h1_rvalid;
  logic [3:0]  h1_be;
  logic [31:0] h1_addr, h1_wdata;
  logic [31:0] host_rdata;
  logic        host_err;
  logic        dev_req, dev_we;
  logic [3:0]  dev_be;
  logic [31:0] dev_addr, dev_wdata;
  logic        dev_gnt, dev_rvalid, dev_err;
  logic [31:0] dev_rdata;
  logic        unexp;

  int total = 0;
  int bad   = 0;

  // reference model state
  int mq[$];
  int m_last;
  bit m_lock_v;
  int m_lock_h;
  bit m_sticky;

  // model predictions for the current cycle
  int          e_w;
  bit          e_dev_req, e_hs, e_pop, e_g0, e_g1, e_rv0, e_rv1;
  logic [31:0] e_addr, e_wdata;
  logic        e_we;
  logic [3:0]  e_be;

  // previous-cycle host view for the protocol assertion
  bit          p0_req, p1_req, p0_gnt, p1_gnt, p1_we;
  logic [31:0] p0_addr, p1_addr, p1_wdata;
  logic [3:0]  p1_be;

  mem_bus_arbiter #(
    .AddrWidth(32), .DataWidth(32), .MaxOutstanding(MAXO), .FixedPriority(FIXED)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .h0_req_i(h0_req), .h0_addr_i(h0_addr), .h0_gnt_o(h0_gnt), .h0_rvalid_o(h0_rvalid),
    .h1_req_i(h1_req), .h1_we_i(h1_we), .h1_be_i(h1_be), .h1_addr_i(h1_addr),
    .h1_wdata_i(h1_wdata), .h1_gnt_o(h1_gnt), .h1_rvalid_o(h1_rvalid),
    .host_rdata_o(host_rdata), .host_err_o(host_err),
    .dev_req_o(dev_req), .dev_we_o(dev_we), .dev_be_o(dev_be), .dev_addr_o(dev_addr),
    .dev_wdata_o(dev_wdata), .dev_gnt_i(dev_gnt), .dev_rvalid_i(dev_rvalid),
    .dev_rdata_i(dev_rdata), .dev_err_i(dev_err),
    .unexpected_rvalid_o(unexp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    h0_req = 0; h0_addr = '0;
    h1_req = 0; h1_we = 0; h1_be = '0; h1_addr = '0; h1_wdata = '0;
    dev_gnt = 0; dev_rvalid = 0; dev_rdata = '0; dev_err = 0;
  endtask

  task automatic model_reset();
    mq.delete();
    m_last = 1;
    m_lock_v = 0;
    m_lock_h = 0;
    m_sticky = 0;
    p0_req = 0; p1_req = 0; p0_gnt = 0; p1_gnt = 0;
  endtask

  // Apply the arbitration rules to the current inputs.
  task automatic predict();
    bit any;
    any = h0_req || h1_req;
    if (m_lock_v) e_w = m_lock_h;
    else if (h0_req && !h1_req) e_w = 0;
    else if (h1_req && !h0_req) e_w = 1;
    else if (h0_req && h1_req) e_w = FIXED ? 1 : 1 - m_last;
    else e_w = 0;
    e_dev_req = any && (mq.size() < MAXO);
    e_hs = e_dev_req && dev_gnt;
    e_g0 = e_hs && (e_w == 0);
    e_g1 = e_hs && (e_w == 1);
    e_addr = '0; e_we = 0; e_be = '0; e_wdata = '0;
    if (any) begin
      if (e_w == 1) begin
        e_addr = h1_addr; e_we = h1_we; e_be = h1_be; e_wdata = h1_wdata;
      end else begin
        e_addr = h0_addr; e_be = 4'hF;
      end
    end
    e_pop = dev_rvalid && (mq.size() > 0);
    e_rv0 = 0; e_rv1 = 0;
    if (e_pop) begin
      e_rv0 = (mq[0] == 0);
      e_rv1 = (mq[0] == 1);
    end
  endtask

  // One clock: protocol assertion, edge, model update, return at negedge.
  task automatic tick();
    #1;
    predict();
    if (p0_req && !p0_gnt) begin
      total++;
      if (!(h0_req === 1'b1 && h0_addr === p0_addr)) begin
        bad++;
        $display("FAIL h0_protocol req=%0b addr=%0h want held addr=%0h", h0_req, h0_addr, p0_addr);
      end
    end
    if (p1_req && !p1_gnt) begin
      total++;
      if (!(h1_req === 1'b1 && h1_addr === p1_addr && h1_we === p1_we &&
            h1_be === p1_be && h1_wdata === p1_wdata)) begin
        bad++;
        $display("FAIL h1_protocol req=%0b addr=%0h want held addr=%0h", h1_req, h1_addr, p1_addr);
      end
    end
    p0_req = h0_req; p0_gnt = e_g0; p0_addr = h0_addr;
    p1_req = h1_req; p1_gnt = e_g1; p1_addr = h1_addr;
    p1_we = h1_we; p1_be = h1_be; p1_wdata = h1_wdata;
    @(posedge clk);
    if (dev_rvalid && mq.size() == 0) m_sticky = 1;
    if (e_pop) void'(mq.pop_front());
    if (e_hs) begin
      mq.push_back(e_w);
      m_last = e_w;
      m_lock_v = 0;
    end else if (e_dev_req) begin
      m_lock_v = 1;
      m_lock_h = e_w;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    idle_inputs();
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic drain();
    idle_inputs();
    for (int i = 0; i < 8 && mq.size() > 0; i++) begin
      dev_rvalid = 1;
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++;
    if ({dev_req, dev_we, h0_gnt, h1_gnt, h0_rvalid, h1_rvalid, host_err, unexp} !== 8'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=0", {dev_req, dev_we, h0_gnt, h1_gnt, h0_rvalid, h1_rvalid, host_err, unexp});
    end
    total++;
    if (dev_addr !== 0 || dev_be !== 0 || dev_wdata !== 0 || host_rdata !== 0) begin
      bad++;
      $display("FAIL reset_data addr=%0h be=%0h wdata=%0h rdata=%0h want=0", dev_addr, dev_be, dev_wdata, host_rdata);
    end
    dev_gnt = 1;
    #1;
    total++;
    if ({dev_req, h0_gnt, h1_gnt} !== 3'b0) begin
      bad++;
      $display("FAIL idle_gnt got=%b want=000", {dev_req, h0_gnt, h1_gnt});
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_single_read();
    h0_req = 1; h0_addr = 32'h80; dev_gnt = 1;
    #1;
    total++;
    if (h0_gnt !== 1 || h1_gnt !== 0 || dev_req !== 1) begin
      bad++;
      $display("FAIL single_gnt h0=%0b h1=%0b req=%0b want 1 0 1", h0_gnt, h1_gnt, dev_req);
    end
    total++;
    if (dev_addr !== 32'h80 || dev_be !== 4'hF || dev_we !== 0 || dev_wdata !== 0) begin
      bad++;
      $display("FAIL single_fields addr=%0h be=%0h we=%0b want 80 f 0", dev_addr, dev_be, dev_we);
    end
    tick();
    idle_inputs();
    dev_rvalid = 1; dev_rdata = 32'hDEADBEEF;
    #1;
    total++;
    if (h0_rvalid !== 1 || h1_rvalid !== 0 || host_rdata !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL single_resp rv0=%0b rv1=%0b rdata=%0h want 1 0 deadbeef", h0_rvalid, h1_rvalid, host_rdata);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_round_robin();
    int g, o;
    do_reset();
    h0_addr = 32'h100; h1_addr = 32'h200; h1_be = 4'hF;
    for (int c = 0; c <= 5; c++) begin
      h0_req = (c <= 4); h1_req = (c < 4);
      dev_gnt = 1; dev_rvalid = (c >= 1); dev_rdata = 32'h1000 + c;
      g = c % 2;
      o = (c - 1) % 2;
      #1;
      if (c <= 4) begin
        total++;
        if (h0_gnt !== (g == 0) || h1_gnt !== (g == 1) || dev_addr !== (g ? 32'h200 : 32'h100)) begin
          bad++;
          $display("FAIL rr_grant c=%0d h0=%0b h1=%0b addr=%0h want host %0d", c, h0_gnt, h1_gnt, dev_addr, g);
        end
      end
      if (c >= 1) begin
        total++;
        if (h0_rvalid !== (o == 0) || h1_rvalid !== (o == 1) || host_rdata !== 32'h1000 + c) begin
          bad++;
          $display("FAIL rr_resp c=%0d rv0=%0b rv1=%0b rdata=%0h want owner %0d", c, h0_rvalid, h1_rvalid, host_rdata, o);
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_grant_lock();
    do_reset();
    h0_req = 1; h0_addr = 32'hA00;
    h1_req = 1; h1_addr = 32'hB00; h1_be = 4'hF;
    for (int c = 0; c < 4; c++) begin
      dev_gnt = (c == 3);
      #1;
      total++;
      if (dev_req !== 1 || dev_addr !== 32'hA00 || h0_gnt !== (c == 3) || h1_gnt !== 0) begin
        bad++;
        $display("FAIL lock_hold c=%0d req=%0b addr=%0h h0=%0b h1=%0b want addr a00", c, dev_req, dev_addr, h0_gnt, h1_gnt);
      end
      tick();
    end
    h0_req = 0; dev_gnt = 1;
    #1;
    total++;
    if (h1_gnt !== 1 || dev_addr !== 32'hB00) begin
      bad++;
      $display("FAIL lock_next h1=%0b addr=%0h want 1 b00", h1_gnt, dev_addr);
    end
    tick();
    drain();
    // host 1 asks alone, then host 0 joins while the device stalls
    h1_req = 1; h1_addr = 32'hC00; h1_be = 4'hF;
    tick();
    tick();
    h0_req = 1; h0_addr = 32'hD00;
    #1;
    total++;
    if (dev_addr !== 32'hC00 || h0_gnt !== 0) begin
      bad++;
      $display("FAIL lock_preempt addr=%0h h0=%0b want c00 0", dev_addr, h0_gnt);
    end
    tick();
    dev_gnt = 1;
    #1;
    total++;
    if (h1_gnt !== 1 || h0_gnt !== 0 || dev_addr !== 32'hC00) begin
      bad++;
      $display("FAIL lock_release h1=%0b h0=%0b addr=%0h want 1 0 c00", h1_gnt, h0_gnt, dev_addr);
    end
    tick();
    h1_req = 0;
    tick();
    drain();
  endtask

  task automatic test_fifo_full();
    do_reset();
    h0_req = 1; h0_addr = 32'h300; dev_gnt = 1;
    for (int c = 0; c < 2; c++) begin
      #1;
      total++;
      if (h0_gnt !== 1) begin
        bad++;
        $display("FAIL full_fill c=%0d h0_gnt=%0b want 1", c, h0_gnt);
      end
      tick();
    end
    #1;
    total++;
    if (dev_req !== 0 || h0_gnt !== 0) begin
      bad++;
      $display("FAIL full_block req=%0b gnt=%0b want 0 0", dev_req, h0_gnt);
    end
    tick();
    dev_rvalid = 1;
    #1;
    total++;
    if (dev_req !== 0 || h0_gnt !== 0 || h0_rvalid !== 1) begin
      bad++;
      $display("FAIL full_samecycle req=%0b gnt=%0b rv0=%0b want 0 0 1", dev_req, h0_gnt, h0_rvalid);
    end
    tick();
    dev_rvalid = 0;
    #1;
    total++;
    if (dev_req !== 1 || h0_gnt !== 1) begin
      bad++;
      $display("FAIL full_unblock req=%0b gnt=%0b want 1 1", dev_req, h0_gnt);
    end
    tick();
    drain();
  endtask

  task automatic test_write_err();
    h1_req = 1; h1_we = 1; h1_be = 4'h3; h1_wdata = 32'h1234; h1_addr = 32'h40; dev_gnt = 1;
    #1;
    total++;
    if (dev_we !== 1 || dev_be !== 4'h3 || dev_wdata !== 32'h1234 || dev_addr !== 32'h40 || h1_gnt !== 1) begin
      bad++;
      $display("FAIL write_fields we=%0b be=%0h wdata=%0h addr=%0h gnt=%0b want 1 3 1234 40 1", dev_we, dev_be, dev_wdata, dev_addr, h1_gnt);
    end
    tick();
    idle_inputs();
    dev_rvalid = 1; dev_err = 1;
    #1;
    total++;
    if (h1_rvalid !== 1 || h0_rvalid !== 0 || host_err !== 1) begin
      bad++;
      $display("FAIL write_err rv1=%0b rv0=%0b err=%0b want 1 0 1", h1_rvalid, h0_rvalid, host_err);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_spurious_reset();
    do_reset();
    dev_rvalid = 1;
    #1;
    total++;
    if (h0_rvalid !== 0 || h1_rvalid !== 0) begin
      bad++;
      $display("FAIL spur_rvalid rv0=%0b rv1=%0b want 0 0", h0_rvalid, h1_rvalid);
    end
    tick();
    dev_rvalid = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (unexp !== 1) begin
        bad++;
        $display("FAIL spur_sticky c=%0d flag=%0b want 1", c, unexp);
      end
      tick();
    end
    h0_req = 1; h0_addr = 32'h10; dev_gnt = 1;
    tick();
    h0_req = 0; h1_req = 1; h1_addr = 32'h20; h1_be = 4'hF;
    tick();
    idle_inputs();
    rst = 1;
    #1;
    total++;
    if (unexp !== 0 || dev_req !== 0) begin
      bad++;
      $display("FAIL midreset flag=%0b req=%0b want 0 0", unexp, dev_req);
    end
    model_reset();
    @(negedge clk);
    rst = 0;
    dev_rvalid = 1;
    #1;
    total++;
    if (h0_rvalid !== 0 || h1_rvalid !== 0) begin
      bad++;
      $display("FAIL stale_resp rv0=%0b rv1=%0b want 0 0", h0_rvalid, h1_rvalid);
    end
    tick();
    dev_rvalid = 0;
    #1;
    total++;
    if (unexp !== 1) begin
      bad++;
      $display("FAIL stale_flag flag=%0b want 1", unexp);
    end
    do_reset();
    h0_req = 1; h0_addr = 32'h30; h1_req = 1; h1_addr = 32'h40; h1_be = 4'hF; dev_gnt = 1;
    #1;
    total++;
    if (h0_gnt !== 1 || h1_gnt !== 0) begin
      bad++;
      $display("FAIL post_reset_tie h0=%0b h1=%0b want 1 0", h0_gnt, h1_gnt);
    end
    tick();
    h0_req = 0;
    tick();
    drain();
  endtask

  task automatic test_random();
    bit pend0, pend1;
    do_reset();
    pend0 = 0; pend1 = 0;
    for (int c = 0; c < 400; c++) begin
      if (!pend0 && $urandom_range(0, 1) == 1) begin
        pend0 = 1; h0_addr = $urandom;
      end
      if (!pend1 && $urandom_range(0, 1) == 1) begin
        pend1 = 1; h1_addr = $urandom; h1_we = 1'($urandom_range(0, 1));
        h1_be = 4'($urandom_range(0, 15)); h1_wdata = $urandom;
      end
      h0_req = pend0; h1_req = pend1;
      dev_gnt = ($urandom_range(0, 3) != 0);
      dev_rvalid = (mq.size() > 0) && ($urandom_range(0, 2) == 0);
      dev_rdata = $urandom; dev_err = ($urandom_range(0, 7) == 0);
      #1;
      predict();
      total++;
      if ({dev_req, dev_we, dev_be, dev_addr, dev_wdata} !== {e_dev_req, e_we, e_be, e_addr, e_wdata}) begin
        bad++;
        $display("FAIL rnd_dev c=%0d req=%0b addr=%0h be=%0h want req=%0b addr=%0h be=%0h", c, dev_req, dev_addr, dev_be, e_dev_req, e_addr, e_be);
      end
      total++;
      if ({h0_gnt, h1_gnt} !== {e_g0, e_g1}) begin
        bad++;
        $display("FAIL rnd_gnt c=%0d got=%b want=%b", c, {h0_gnt, h1_gnt}, {e_g0, e_g1});
      end
      total++;
      if ({h0_rvalid, h1_rvalid} !== {e_rv0, e_rv1}) begin
        bad++;
        $display("FAIL rnd_rvalid c=%0d got=%b want=%b", c, {h0_rvalid, h1_rvalid}, {e_rv0, e_rv1});
      end
      total++;
      if (host_rdata !== dev_rdata || host_err !== dev_err) begin
        bad++;
        $display("FAIL rnd_payload c=%0d rdata=%0h err=%0b want %0h %0b", c, host_rdata, host_err, dev_rdata, dev_err);
      end
      total++;
      if (unexp !== m_sticky) begin
        bad++;
        $display("FAIL rnd_flag c=%0d got=%0b want=%0b", c, unexp, m_sticky);
      end
      if (e_g0) pend0 = 0;
      if (e_g1) pend1 = 0;
      tick();
    end
    // let pending hosts finish legally, then collect responses
    for (int i = 0; i < 16 && (pend0 || pend1); i++) begin
      h0_req = pend0; h1_req = pend1; dev_gnt = 1;
      dev_rvalid = (mq.size() > 0);
      #1;
      predict();
      if (e_g0) pend0 = 0;
      if (e_g1) pend1 = 0;
      tick();
    end
    total++;
    if (pend0 || pend1) begin
      bad++;
      $display("FAIL rnd_finish pending=%b want 00", {pend0, pend1});
    end
    drain();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    model_reset();
    test_reset();
    test_single_read();
    test_round_robin();
    test_grant_lock();
    test_fifo_full();
    test_write_err();
    test_spurious_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
